// File: rtl/lane_merge_pkg.sv
// rtl/lane_merge_pkg.sv - shared defaults, pointer width helper and lane type for lane_merge
// Purpose: parameters and types common to lane_merge and lane_fifo.
// Ports: none (package).
package lane_merge_pkg;

   localparam int LM_WIDTH = 8;
   localparam int LM_DEPTH = 4;

   // A 1-entry FIFO still needs a 1-bit pointer to index its storage.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int LM_PTR_W = ptr_w(LM_DEPTH);

   typedef enum logic {
      LANE0 = 1'b0,
      LANE1 = 1'b1
   } lane_e;

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - per-lane word FIFO with drop-on-full and sticky overflow flag
// Purpose: DEPTH-entry circular buffer for one merge lane.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   wr_valid_i, wr_data_i : incoming word from the demux lane
//   rd_en_i               : pop the head word this edge (ignored when empty)
//   rd_data_o             : head word, valid whenever empty_o=0
//   empty_o, full_o       : occupancy flags from the registered count
//   ovf_o                 : sticky, a word was dropped since reset
module lane_fifo
   import lane_merge_pkg::*;
#(
   parameter int WIDTH = LM_WIDTH,
   parameter int DEPTH = LM_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             ovf_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             pop;
   logic             push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == CW'(DEPTH));
   assign ovf_o     = ovf_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // A full FIFO still takes a word when its head leaves on the same edge.
   assign pop  = rd_en_i && !empty_o;
   assign push = wr_valid_i && (!full_o || pop);

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      ovf_d    = ovf_q || (wr_valid_i && !push);
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: the count guards every read.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/lane_merge.sv
// rtl/lane_merge.sv - 2:1 lane merger with per-lane FIFOs and round-robin output register
// Purpose: recombine two demuxed lanes into one registered stream.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   data_in0/1, valid_in0/1        : lane input words
//   ready_in                       : downstream accepts data_out this cycle
//   data_out, valid_out, lane_out  : registered merged word and its source lane
//   full0/1                        : lane FIFO holds DEPTH words
//   ovf0/1                         : sticky, a lane word was dropped since reset
module lane_merge
   import lane_merge_pkg::*;
#(
   parameter int WIDTH = LM_WIDTH,
   parameter int DEPTH = LM_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in0,
   input  logic [WIDTH-1:0] data_in1,
   input  logic             valid_in0,
   input  logic             valid_in1,
   input  logic             ready_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             lane_out,
   output logic             full0,
   output logic             full1,
   output logic             ovf0,
   output logic             ovf1
);

   logic [WIDTH-1:0] rd_data0, rd_data1;
   logic             empty0, empty1;
   logic             pop0, pop1;
   logic             load_slot;
   logic             pick_valid;
   lane_e            pick_lane;

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             lane_q, lane_d;
   lane_e            last_lane_q, last_lane_d;

   lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
      .clk        (clk),
      .reset      (reset),
      .wr_valid_i (valid_in0),
      .wr_data_i  (data_in0),
      .rd_en_i    (pop0),
      .rd_data_o  (rd_data0),
      .empty_o    (empty0),
      .full_o     (full0),
      .ovf_o      (ovf0)
   );

   lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
      .clk        (clk),
      .reset      (reset),
      .wr_valid_i (valid_in1),
      .wr_data_i  (data_in1),
      .rd_en_i    (pop1),
      .rd_data_o  (rd_data1),
      .empty_o    (empty1),
      .full_o     (full1),
      .ovf_o      (ovf1)
   );

   // The output register may take a new word when it is empty or being drained.
   assign load_slot = !valid_q || ready_in;

   // Round robin on ties: the lane that did not supply the last word wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_lane  = LANE0;
      if (load_slot) begin
         if (!empty0 && !empty1) begin
            pick_valid = 1'b1;
            pick_lane  = (last_lane_q == LANE0) ? LANE1 : LANE0;
         end else if (!empty0) begin
            pick_valid = 1'b1;
            pick_lane  = LANE0;
         end else if (!empty1) begin
            pick_valid = 1'b1;
            pick_lane  = LANE1;
         end
      end
   end

   assign pop0 = pick_valid && (pick_lane == LANE0);
   assign pop1 = pick_valid && (pick_lane == LANE1);

   always_comb begin
      data_d      = data_q;
      valid_d     = valid_q;
      lane_d      = lane_q;
      last_lane_d = last_lane_q;
      if (load_slot) begin
         valid_d = pick_valid;
         if (pick_valid) begin
            data_d      = (pick_lane == LANE1) ? rd_data1 : rd_data0;
            lane_d      = pick_lane;
            last_lane_d = pick_lane;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q      <= '0;
         valid_q     <= 1'b0;
         lane_q      <= 1'b0;
         last_lane_q <= LANE1;
      end else begin
         data_q      <= data_d;
         valid_q     <= valid_d;
         lane_q      <= lane_d;
         last_lane_q <= last_lane_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign lane_out  = lane_q;

endmodule

// File: tb/tb_lane_merge.sv
// tb/tb_lane_merge.sv - scoreboard bench for lane_merge with queue-based reference model
module tb_lane_merge;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in0 = '0, data_in1 = '0;
   logic       valid_in0 = 1'b0, valid_in1 = 1'b0;
   logic       ready_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out, lane_out, full0, full1, ovf0, ovf1;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [8:0] exp_q[$];
   logic       m_valid, m_lane, m_last, m_ovf0, m_ovf1;
   logic [7:0] m_data;

   lane_merge #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in0  (data_in0),
      .data_in1  (data_in1),
      .valid_in0 (valid_in0),
      .valid_in1 (valid_in1),
      .ready_in  (ready_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .lane_out  (lane_out),
      .full0     (full0),
      .full1     (full1),
      .ovf0      (ovf0),
      .ovf1      (ovf1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: two bounded word queues plus an output slot, advanced once per edge.
   task automatic model(input logic v0, input logic [7:0] d0, input logic v1,
                        input logic [7:0] d1, input logic rdy, input logic rst);
      int sel;
      if (rst) begin
         q0.delete(); q1.delete(); exp_q.delete();
         m_valid = 0; m_data = 0; m_lane = 0; m_last = 1; m_ovf0 = 0; m_ovf1 = 0;
         return;
      end
      sel = -1;
      if (!m_valid || rdy) begin
         if (q0.size() > 0 && q1.size() > 0) sel = m_last ? 0 : 1;
         else if (q0.size() > 0)             sel = 0;
         else if (q1.size() > 0)             sel = 1;
         if (sel == 0) m_data = q0.pop_front();
         if (sel == 1) m_data = q1.pop_front();
         if (sel >= 0) begin
            m_valid = 1; m_lane = sel[0]; m_last = sel[0];
            exp_q.push_back({m_lane, m_data});
         end else begin
            m_valid = 0;
         end
      end
      if (v0) begin
         if (q0.size() < DEPTH) q0.push_back(d0); else m_ovf0 = 1;
      end
      if (v1) begin
         if (q1.size() < DEPTH) q1.push_back(d1); else m_ovf1 = 1;
      end
   endtask

   task automatic step(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic rdy, input logic rst);
      reset = rst; valid_in0 = v0; data_in0 = d0; valid_in1 = v1; data_in1 = d1; ready_in = rdy;
      @(posedge clk);
      #1;
      model(v0, d0, v1, d1, rdy, rst);
      chk("valid_out", valid_out, m_valid);
      chk("data_out",  data_out,  m_data);
      chk("lane_out",  lane_out,  m_lane);
      chk("full0",     full0,     q0.size() == DEPTH);
      chk("full1",     full1,     q1.size() == DEPTH);
      chk("ovf0",      ovf0,      m_ovf0);
      chk("ovf1",      ovf1,      m_ovf1);
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, rdy, 0);
   endtask

   // Monitor: each transfer must match the oldest word the model loaded.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && valid_out === 1'b1 && ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_underflow: got word %0h expected no transfer", data_out);
            end else begin
               e = exp_q.pop_front();
               chk("sb_data", data_out, e[7:0]);
               chk("sb_lane", lane_out, e[8]);
            end
         end
      end
   end

   initial begin
      logic [7:0] seq_d [4];
      logic       seq_l [4];
      seq_d = '{8'h10, 8'h20, 8'h11, 8'h21};
      seq_l = '{1'b0, 1'b1, 1'b0, 1'b1};

      // Reset held for two edges with lane 0 driving.
      step(1, 8'h33, 0, 8'h00, 0, 1);
      step(1, 8'h33, 0, 8'h00, 0, 1);
      chk("rst_valid", valid_out, 0);
      chk("rst_data",  data_out,  0);
      chk("rst_full0", full0,     0);
      chk("rst_ovf0",  ovf0,      0);

      // Single word, write on first edge out of reset, one-edge latency.
      step(1, 8'hA5, 0, 8'h00, 1, 0);
      chk("lat_wr_valid", valid_out, 0);
      step(0, 8'h00, 0, 8'h00, 1, 0);
      chk("lat_data",  data_out,  8'hA5);
      chk("lat_lane",  lane_out,  0);
      chk("lat_valid", valid_out, 1);
      step(0, 8'h00, 0, 8'h00, 1, 0);
      chk("lat_drain", valid_out, 0);

      // Both lanes together: lane 0 wins the first tie, then alternate.
      step(0, 8'h00, 0, 8'h00, 0, 1);
      step(1, 8'h10, 1, 8'h20, 1, 0);
      step(1, 8'h11, 1, 8'h21, 1, 0);
      for (int i = 0; i < 4; i++) begin
         chk("tie_data", data_out, seq_d[i]);
         chk("tie_lane", lane_out, seq_l[i]);
         step(0, 8'h00, 0, 8'h00, 1, 0);
      end
      chk("tie_done", valid_out, 0);

      // Backpressure fills lane 0; sixth word is dropped.
      step(0, 8'h00, 0, 8'h00, 0, 1);
      for (int i = 1; i <= 6; i++) begin
         step(1, 8'(i), 0, 8'h00, 0, 0);
         if (i == 5) chk("bp_full0_at5", full0, 1);
      end
      chk("bp_hold",  data_out, 8'h01);
      chk("bp_valid", valid_out, 1);
      chk("bp_full0", full0, 1);
      chk("bp_ovf0",  ovf0, 1);
      idle(1, 7);
      chk("bp_empty", valid_out, 0);
      chk("bp_ovf_sticky", ovf0, 1);

      // Full lane 1 accepts a word when its head leaves on the same edge.
      step(0, 8'h00, 0, 8'h00, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 8'h31 + 8'(i), 0, 0);
      chk("sp_full1_pre", full1, 1);
      step(0, 8'h00, 1, 8'h7F, 1, 0);
      chk("sp_full1", full1, 1);
      chk("sp_ovf1",  ovf1, 0);
      chk("sp_data",  data_out, 8'h32);
      idle(1, 6);
      chk("sp_ovf1_end", ovf1, 0);

      // Reset mid-stream with three words buffered behind the output slot.
      step(0, 8'h00, 0, 8'h00, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 8'h41 + 8'(i), 0, 8'h00, 0, 0);
      step(1, 8'h55, 1, 8'h66, 1, 1);
      chk("mid_valid", valid_out, 0);
      chk("mid_full0", full0, 0);
      chk("mid_full1", full1, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 8'h00, 0, 8'h00, 1, 0);
         chk("mid_stale", valid_out, 0);
      end

      // Continuous feed on both lanes at full rate alternates every cycle.
      step(0, 8'h00, 0, 8'h00, 0, 1);
      for (int i = 0; i < 10; i++) begin
         step(1, 8'(i), 1, 8'h80 + 8'(i), 1, 0);
         if (i >= 1) begin
            chk("alt_valid", valid_out, 1);
            chk("alt_lane",  lane_out, 32'((i - 1) & 1));
         end
      end
      idle(1, 10);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 55,
              8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      end
      idle(1, 12);
      chk("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
